// File: rtl/window_gen_pkg.sv
// Shared types and elaboration-time helpers for the sliding-window generator.
package window_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      STALL
   } state_t;

   // Number of window positions along one image dimension.
   function automatic int out_dim(input int n, input int f, input int s);
      return (n - f) / s + 1;
   endfunction

   // Bits needed to hold values 0..v-1, never less than one.
   function automatic int clog2min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/window_gen_if.sv
// Pixel-in / window-out stream bundle for window_gen.
interface window_gen_if import window_gen_pkg::*; #(
   parameter int N           = 5,
   parameter int C           = 1,
   parameter int F           = 3,
   parameter int S           = 1,
   parameter int indatawidth = 8
);
   localparam int O  = out_dim(N, F, S);
   localparam int XW = clog2min1(O);

   logic                                            in_valid;
   logic                                            in_ready;
   logic [C-1:0][indatawidth-1:0]                   in_pix;
   logic                                            out_valid;
   logic                                            out_ready;
   logic [F-1:0][F-1:0][C-1:0][indatawidth-1:0]     out_win;
   logic [XW-1:0]                                   out_xo;
   logic [XW-1:0]                                   out_yo;
   logic                                            out_last;

   modport master (
      output in_valid, in_pix, out_ready,
      input  in_ready, out_valid, out_win, out_xo, out_yo, out_last
   );

   modport slave (
      input  in_valid, in_pix, out_ready,
      output in_ready, out_valid, out_win, out_xo, out_yo, out_last
   );

endinterface

// File: rtl/window_gen_line_buffer.sv
// F-1 image lines of N pixels; one column is read, shifted up and refilled per accept.
module window_gen_line_buffer import window_gen_pkg::*; #(
   parameter int N           = 5,
   parameter int F           = 3,
   parameter int C           = 1,
   parameter int indatawidth = 8,
   localparam int AW         = clog2min1(N)
) (
   input  logic                                  clk,
   input  logic                                  wr_en,
   input  logic [AW-1:0]                         addr,
   input  logic [C-1:0][indatawidth-1:0]         wr_pix,
   output logic [F-2:0][C-1:0][indatawidth-1:0]  rd_col
);

   logic [C-1:0][indatawidth-1:0] mem [F-1][N];

   // Combinational read: line 0 is the oldest row, line F-2 the newest.
   always_comb begin
      rd_col = '0;
      for (int unsigned j = 0; j < F - 1; j++) rd_col[j] = mem[j][addr];
   end

   // Column shift toward the oldest line, new pixel into the newest line.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned j = 0; j + 2 < F; j++) mem[j][addr] <= mem[j+1][addr];
         mem[F-2][addr] <= wr_pix;
      end
   end

endmodule

// File: rtl/window_gen.sv
// Streaming F x F x C window generator: raster pixels in, stride-S windows out.
module window_gen import window_gen_pkg::*; #(
   parameter int N           = 5,
   parameter int C           = 1,
   parameter int F           = 3,
   parameter int S           = 1,
   parameter int indatawidth = 8
) (
   input logic          clk,
   input logic          rst_n,
   window_gen_if.slave  bus
);
   localparam int O  = out_dim(N, F, S);
   localparam int XW = clog2min1(O);
   localparam int AW = clog2min1(N);
   localparam int PW = clog2min1(S);

   typedef logic [F-1:0][C-1:0][indatawidth-1:0]        col_t;
   typedef logic [F-1:0][F-1:0][C-1:0][indatawidth-1:0] win_t;

   logic [AW-1:0]                             x, y;
   logic [PW-1:0]                             xph, yph;
   logic [XW-1:0]                             xo_cnt, yo_cnt;
   logic [F-2:0][C-1:0][indatawidth-1:0]      lb_col;
   col_t                                      new_col;
   win_t                                      wreg, win_nxt;
   logic                                      accept, x_last, y_last, x_in, y_in, emit;
   state_t                                    state, state_nxt, ret, ret_nxt, cur;

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign x_last       = (x == AW'(N - 1));
   assign y_last       = (y == AW'(N - 1));
   assign x_in         = (x >= AW'(F - 1));
   assign y_in         = (y >= AW'(F - 1));
   // Phase counters stand in for (pos-F+1)%S so no divider is needed.
   assign emit         = x_in && y_in && (xph == '0) && (yph == '0);
   assign new_col      = {bus.in_pix, lb_col};
   assign win_nxt      = {new_col, wreg[F-1:1]};

   window_gen_line_buffer #(
      .N(N), .F(F), .C(C), .indatawidth(indatawidth)
   ) u_lb (
      .clk    (clk),
      .wr_en  (accept),
      .addr   (x),
      .wr_pix (bus.in_pix),
      .rd_col (lb_col)
   );

   // Raster position, stride phase and window-index counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0; y <= '0; xph <= '0; yph <= '0; xo_cnt <= '0; yo_cnt <= '0;
      end else if (accept) begin
         if (x_last) begin
            x <= '0; xph <= '0; xo_cnt <= '0;
            if (y_last) begin
               y <= '0; yph <= '0; yo_cnt <= '0;
            end else begin
               y <= y + 1'b1;
               if (y_in) begin
                  yph <= (yph == PW'(S - 1)) ? '0 : yph + 1'b1;
                  if (yph == '0) yo_cnt <= yo_cnt + 1'b1;
               end
            end
         end else begin
            x <= x + 1'b1;
            if (x_in) begin
               xph <= (xph == PW'(S - 1)) ? '0 : xph + 1'b1;
               if (xph == '0) xo_cnt <= xo_cnt + 1'b1;
            end
         end
      end
   end

   // Window shift register and registered output window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wreg          <= '0;
         bus.out_valid <= 1'b0;
         bus.out_win   <= '0;
         bus.out_xo    <= '0;
         bus.out_yo    <= '0;
         bus.out_last  <= 1'b0;
      end else if (accept) begin
         wreg          <= win_nxt;
         bus.out_valid <= emit;
         if (emit) begin
            bus.out_win  <= win_nxt;
            bus.out_xo   <= xo_cnt;
            bus.out_yo   <= yo_cnt;
            bus.out_last <= (xo_cnt == XW'(O - 1)) && (yo_cnt == XW'(O - 1));
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Frame-phase state register; ret remembers where a stall came from.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ret   <= IDLE;
      end else begin
         state <= state_nxt;
         ret   <= ret_nxt;
      end
   end

   // Frame-phase next state; a stall freezes the phase it interrupted.
   always_comb begin
      state_nxt = state;
      ret_nxt   = ret;
      cur       = (state == STALL) ? ret : state;
      case (cur)
         IDLE: if (accept) state_nxt = FILL;
         FILL: begin
            state_nxt = FILL;
            if (accept && x_last && (y == AW'(F - 2))) state_nxt = RUN;
         end
         RUN: begin
            state_nxt = RUN;
            if ((x == '0) && (y == '0)) begin
               if (accept) state_nxt = FILL;
               else if (!bus.out_valid || bus.out_ready) state_nxt = IDLE;
            end else if (accept && x_last && y_last && !emit) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.out_valid && !bus.out_ready) begin
         state_nxt = STALL;
         ret_nxt   = cur;
      end
   end

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench: two window_gen instances (stride 1 and 2) against an image-array model.
module tb_window_gen;
   localparam int N = 5, F = 3, C = 1, W = 8;
   typedef logic [F-1:0][F-1:0][C-1:0][W-1:0] win_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   window_gen_if #(.N(N), .C(C), .F(F), .S(1), .indatawidth(W)) b0 ();
   window_gen_if #(.N(N), .C(C), .F(F), .S(2), .indatawidth(W)) b1 ();

   window_gen #(.N(N), .C(C), .F(F), .S(1), .indatawidth(W)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0.slave));
   window_gen #(.N(N), .C(C), .F(F), .S(2), .indatawidth(W)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1.slave));

   logic         iv[2];
   logic [W-1:0] px[2];
   logic         ordy[2];

   assign b0.in_valid  = iv[0];
   assign b0.in_pix[0] = px[0];
   assign b0.out_ready = ordy[0];
   assign b1.in_valid  = iv[1];
   assign b1.in_pix[0] = px[1];
   assign b1.out_ready = ordy[1];

   // observed DUT outputs
   logic ov[2], ir[2], olast[2];
   win_t ow[2];
   int   oxo[2], oyo[2];

   // reference model: current frame image plus the one window in flight
   logic [W-1:0] img[2][N][N];
   int           mx[2], my[2];
   logic         ev[2], elast[2];
   win_t         ew[2];
   int           exo[2], eyo[2];
   logic         lastacc[2];

   // per-test record of windows seen at the DUT
   int   fr_acc[2], nw[2];
   logic newf[2];
   int   wacc[2][64], wxo[2][64], wyo[2][64];
   logic wlast[2][64];
   win_t wobs[2][64];

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic obs_read();
      ov[0] = b0.out_valid; ir[0] = b0.in_ready; ow[0] = b0.out_win;
      oxo[0] = int'(b0.out_xo); oyo[0] = int'(b0.out_yo); olast[0] = b0.out_last;
      ov[1] = b1.out_valid; ir[1] = b1.in_ready; ow[1] = b1.out_win;
      oxo[1] = int'(b1.out_xo); oyo[1] = int'(b1.out_yo); olast[1] = b1.out_last;
   endtask

   task automatic model_accept(input int d);
      int sd, o, x0, y0;
      sd = (d == 0) ? 1 : 2;
      o  = (N - F) / sd + 1;
      img[d][mx[d]][my[d]] = px[d];
      if (mx[d] >= F - 1 && my[d] >= F - 1 &&
          (mx[d] - F + 1) % sd == 0 && (my[d] - F + 1) % sd == 0) begin
         x0 = mx[d] - F + 1;
         y0 = my[d] - F + 1;
         for (int i = 0; i < F; i++)
            for (int j = 0; j < F; j++)
               ew[d][i][j][0] = img[d][x0 + i][y0 + j];
         exo[d]   = x0 / sd;
         eyo[d]   = y0 / sd;
         elast[d] = (exo[d] == o - 1) && (eyo[d] == o - 1);
         ev[d]    = 1'b1;
      end else begin
         ev[d] = 1'b0;
      end
      mx[d]++;
      if (mx[d] == N) begin
         mx[d] = 0;
         my[d]++;
         if (my[d] == N) my[d] = 0;
      end
   endtask

   // Called 1ns after a rising edge; samples mid-cycle, then advances one clock.
   task automatic tick();
      logic acc_v[2], tk_v[2];
      #1;
      obs_read();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_in_ready", d), ir[d], !ev[d] || ordy[d]);
         check($sformatf("d%0d_out_valid", d), ov[d], ev[d]);
         if (ev[d]) begin
            check($sformatf("d%0d_win", d), ow[d], ew[d]);
            check($sformatf("d%0d_xo", d), oxo[d], exo[d]);
            check($sformatf("d%0d_yo", d), oyo[d], eyo[d]);
            check($sformatf("d%0d_last", d), olast[d], elast[d]);
         end
         if (ov[d] && newf[d] && nw[d] < 64) begin
            wacc[d][nw[d]]  = fr_acc[d];
            wobs[d][nw[d]]  = ow[d];
            wxo[d][nw[d]]   = oxo[d];
            wyo[d][nw[d]]   = oyo[d];
            wlast[d][nw[d]] = olast[d];
            nw[d]++;
         end
         newf[d]  = !ov[d] || ordy[d];
         acc_v[d] = iv[d] && (!ev[d] || ordy[d]);
         tk_v[d]  = ev[d] && ordy[d];
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         lastacc[d] = acc_v[d];
         if (acc_v[d]) begin
            fr_acc[d]++;
            model_accept(d);
         end else if (tk_v[d]) begin
            ev[d] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic feed(input int d, input logic [W-1:0] v, input bit rnd);
      int budget;
      budget = 0;
      if (rnd) begin
         repeat ($urandom_range(0, 2)) begin
            iv[d] = 1'b0;
            ordy[d] = ($urandom_range(0, 2) != 0);
            tick();
         end
      end
      iv[d] = 1'b1;
      px[d] = v;
      do begin
         if (rnd) ordy[d] = ($urandom_range(0, 2) != 0);
         tick();
         budget++;
      end while (!lastacc[d] && budget < 40);
      if (!lastacc[d]) check($sformatf("d%0d_feed_timeout", d), lastacc[d], 1'b1);
      iv[d] = 1'b0;
   endtask

   task automatic drain();
      iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b1; ordy[1] = 1'b1;
      repeat (3) tick();
   endtask

   task automatic clear_stats(input int d);
      fr_acc[d] = 0;
      nw[d] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      obs_read();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d_rst_valid", d), ov[d], 1'b0);
         check($sformatf("d%0d_rst_last", d), olast[d], 1'b0);
         check($sformatf("d%0d_rst_xo", d), oxo[d], 0);
         check($sformatf("d%0d_rst_yo", d), oyo[d], 0);
         check($sformatf("d%0d_rst_win", d), ow[d], '0);
         check($sformatf("d%0d_rst_ready", d), ir[d], 1'b1);
         mx[d] = 0; my[d] = 0; ev[d] = 1'b0; newf[d] = 1'b1;
      end
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0; px[d] = '0; ordy[d] = 1'b1; lastacc[d] = 1'b0;
         mx[d] = 0; my[d] = 0; ev[d] = 1'b0; ew[d] = '0; exo[d] = 0; eyo[d] = 0;
         elast[d] = 1'b0; newf[d] = 1'b1; fr_acc[d] = 0; nw[d] = 0;
      end
      #2;
      do_reset();

      // continuous frame, stride 1
      clear_stats(0);
      for (int p = 0; p < 25; p++) feed(0, W'(p + 1), 1'b0);
      drain();
      check("s1_first_acc", wacc[0][0], 13);
      check("s1_w00", wobs[0][0][0][0][0], 8'd1);
      check("s1_w20", wobs[0][0][2][0][0], 8'd3);
      check("s1_w02", wobs[0][0][0][2][0], 8'd11);
      check("s1_w22", wobs[0][0][2][2][0], 8'd13);
      check("s1_count", nw[0], 9);
      check("s1_last_xo", wxo[0][8], 2);
      check("s1_last_yo", wyo[0][8], 2);
      check("s1_last_w22", wobs[0][8][2][2][0], 8'd25);
      check("s1_last_flag", wlast[0][8], 1'b1);

      // consumer back-pressure for 4 cycles on the first window
      clear_stats(0);
      for (int p = 0; p < 13; p++) feed(0, W'(p + 1), 1'b0);
      ordy[0] = 1'b0;
      iv[0] = 1'b1;
      px[0] = 8'd14;
      repeat (4) begin
         tick();
         check("stall_in_ready", ir[0], 1'b0);
         check("stall_valid", ov[0], 1'b1);
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      for (int p = 13; p < 25; p++) feed(0, W'(p + 1), 1'b0);
      drain();
      check("stall_count", nw[0], 9);
      check("stall_first_w00", wobs[0][0][0][0][0], 8'd1);
      check("stall_second_w22", wobs[0][1][2][2][0], 8'd14);
      check("stall_last_w22", wobs[0][8][2][2][0], 8'd25);

      // stride 2
      clear_stats(1);
      for (int p = 0; p < 25; p++) feed(1, W'(p + 1), 1'b0);
      drain();
      check("s2_count", nw[1], 4);
      check("s2_acc0", wacc[1][0], 13);
      check("s2_acc1", wacc[1][1], 15);
      check("s2_acc2", wacc[1][2], 23);
      check("s2_acc3", wacc[1][3], 25);
      check("s2_xo1", wxo[1][1], 1);
      check("s2_yo1", wyo[1][1], 0);
      check("s2_xo2", wxo[1][2], 0);
      check("s2_yo2", wyo[1][2], 1);
      check("s2_w11_00", wobs[1][3][0][0][0], 8'd13);
      check("s2_last", wlast[1][3], 1'b1);

      // two frames back to back
      clear_stats(0);
      for (int p = 0; p < 50; p++) feed(0, W'((p % 25) + 1), 1'b0);
      drain();
      check("b2b_count", nw[0], 18);
      check("b2b_f2_acc", wacc[0][9], 38);
      check("b2b_f2_w00", wobs[0][9][0][0][0], 8'd1);
      check("b2b_f2_w22", wobs[0][9][2][2][0], 8'd13);
      check("b2b_f2_xo", wxo[0][9], 0);
      check("b2b_f1_last", wlast[0][8], 1'b1);

      // reset mid-frame after 17 accepts
      for (int p = 0; p < 17; p++) feed(0, W'(p + 100), 1'b0);
      do_reset();
      clear_stats(0);
      for (int p = 0; p < 25; p++) feed(0, W'(p + 1), 1'b0);
      drain();
      check("rst_first_acc", wacc[0][0], 13);
      check("rst_w00", wobs[0][0][0][0][0], 8'd1);
      check("rst_count", nw[0], 9);
      check("rst_last_w22", wobs[0][8][2][2][0], 8'd25);

      // random pixels, bubbles and back-pressure, three frames per instance
      for (int d = 0; d < 2; d++) begin
         clear_stats(d);
         for (int p = 0; p < 75; p++) feed(d, W'($urandom_range(0, 255)), 1'b1);
         drain();
         check($sformatf("rnd_d%0d_count", d), nw[d], (d == 0) ? 27 : 12);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
